// File: rtl/xosera_bus_port.sv
// xosera_bus_port: synchronizes the asynchronous host bus pins and runs one
// access per select assertion. Each access produces a single-cycle read or
// write strobe toward the register file. Read data is returned on registered
// data and output-enable lines, and DTACK is generated.
module xosera_bus_port #(
    parameter int DATA_W      = 8,
    parameter int REG_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 1,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              bus_cs_n_i,
    input  logic              bus_rd_nwr_i,
    input  logic              bus_bytesel_i,
    input  logic [REG_W-1:0]  bus_reg_num_i,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_out_ena_o,
    output logic              bus_dtack_n_o,
    output logic              wr_strobe_o,
    output logic              rd_strobe_o,
    output logic [REG_W-1:0]  reg_num_o,
    output logic              bytesel_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic [DATA_W-1:0] rd_data_i
);

    localparam int PIN_W = DATA_W + REG_W + 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_RDWAIT = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
    localparam logic [3:0] READ_LAST   = 4'(READ_LAT - 1);

    logic [SYNC_STAGES-1:0]            cs_sync;
    logic [SYNC_STAGES-1:0][PIN_W-1:0] pin_sync;
    logic [SYNC_STAGES-1:0]            fill;

    logic              cs_s;
    logic              cs_next;
    logic              sync_valid;
    logic              rd_nwr_s;
    logic              bytesel_s;
    logic [REG_W-1:0]  reg_num_s;
    logic [DATA_W-1:0] data_s;

    logic [2:0] state;
    logic [3:0] cnt;
    logic       is_read;
    logic       armed;
    logic       latch_now;

    // cs_next is the value cs_s takes at the next edge. Acting on it lets
    // DTACK/out_ena change on the same edge the synchronized select does.
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign cs_next    = cs_sync[SYNC_STAGES-2];
    assign sync_valid = fill[SYNC_STAGES-1];
    assign {rd_nwr_s, bytesel_s, reg_num_s, data_s} = pin_sync[SYNC_STAGES-1];

    // Synchronizer chains for every pin, plus a fill marker that tracks when
    // the reset-time contents of the chains have been flushed out.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cs_sync  <= '1;
            pin_sync <= '0;
            fill     <= '0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus_cs_n_i};
            pin_sync <= {pin_sync[SYNC_STAGES-2:0],
                         {bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i}};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Latch point: end of the settle count, or directly from idle when no settle delay is configured.
    always_comb begin
        latch_now = 1'b0;
        if (state == ST_IDLE) begin
            latch_now = (SETTLE_CYC == 0) && armed && !cs_s;
        end else if (state == ST_SETTLE) begin
            latch_now = !cs_s && (cnt == SETTLE_LAST);
        end
    end

    // Per-access state machine with registered strobes, DTACK and output enable.
    // armed blocks a select held low across reset. It is only set once a genuine high is seen on synchronized cs_n.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            is_read       <= 1'b0;
            armed         <= 1'b0;
            wr_strobe_o   <= 1'b0;
            rd_strobe_o   <= 1'b0;
            bus_dtack_n_o <= 1'b1;
            bus_out_ena_o <= 1'b0;
            bus_data_o    <= '0;
            wr_data_o     <= '0;
            reg_num_o     <= '0;
            bytesel_o     <= 1'b0;
        end else begin
            wr_strobe_o <= 1'b0;
            rd_strobe_o <= 1'b0;
            if (sync_valid && cs_s) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (armed && !cs_s) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (is_read) begin
                        cnt   <= '0;
                        state <= ST_RDWAIT;
                    end else if (!cs_next) begin
                        bus_dtack_n_o <= 1'b0;
                        state         <= ST_ACK;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RDWAIT: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end else if (cnt == READ_LAST) begin
                        bus_data_o <= rd_data_i;
                        if (!cs_next) begin
                            bus_dtack_n_o <= 1'b0;
                            bus_out_ena_o <= 1'b1;
                            state         <= ST_ACK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ACK: begin
                    if (cs_next) begin
                        bus_dtack_n_o <= 1'b1;
                        bus_out_ena_o <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (latch_now) begin
                reg_num_o   <= reg_num_s;
                bytesel_o   <= bytesel_s & (DATA_W != 16);
                wr_data_o   <= data_s;
                is_read     <= rd_nwr_s;
                wr_strobe_o <= !rd_nwr_s;
                rd_strobe_o <= rd_nwr_s;
                state       <= ST_STROBE;
            end
        end
    end

endmodule

// File: tb/tb_xosera_bus_port.sv
// Bench for xosera_bus_port: two instances are used. dut8 is an 8-bit port with sync 2, settle 1 and read latency 2.
// dut16 is a 16-bit port with sync 3, settle 0 and read latency 1. Expected strobes, acks and releases are queued
// by the stimulus and checked by a negedge monitor.
module tb_xosera_bus_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b1;
    logic        cs8_n   = 1'b1;
    logic        cs16_n  = 1'b1;
    logic        rd_nwr  = 1'b0;
    logic        bytesel = 1'b0;
    logic [3:0]  reg_num = '0;
    logic [15:0] wdata   = '0;
    logic [15:0] rdata   = '0;

    logic [7:0]  bus_data8, wr_data8;
    logic        oe8, dtack8_n, wr8, rd8, bs8;
    logic [3:0]  regn8;
    logic [15:0] bus_data16, wr_data16;
    logic        oe16, dtack16_n, wr16, rd16, bs16;
    logic [3:0]  regn16;

    xosera_bus_port #(.DATA_W(8), .REG_W(4), .SYNC_STAGES(2), .SETTLE_CYC(1), .READ_LAT(2)) dut8 (
        .clk(clk), .reset_n_i(reset_n), .bus_cs_n_i(cs8_n), .bus_rd_nwr_i(rd_nwr),
        .bus_bytesel_i(bytesel), .bus_reg_num_i(reg_num), .bus_data_i(wdata[7:0]),
        .bus_data_o(bus_data8), .bus_out_ena_o(oe8), .bus_dtack_n_o(dtack8_n),
        .wr_strobe_o(wr8), .rd_strobe_o(rd8), .reg_num_o(regn8), .bytesel_o(bs8),
        .wr_data_o(wr_data8), .rd_data_i(rdata[7:0])
    );

    xosera_bus_port #(.DATA_W(16), .REG_W(4), .SYNC_STAGES(3), .SETTLE_CYC(0), .READ_LAT(1)) dut16 (
        .clk(clk), .reset_n_i(reset_n), .bus_cs_n_i(cs16_n), .bus_rd_nwr_i(rd_nwr),
        .bus_bytesel_i(bytesel), .bus_reg_num_i(reg_num), .bus_data_i(wdata),
        .bus_data_o(bus_data16), .bus_out_ena_o(oe16), .bus_dtack_n_o(dtack16_n),
        .wr_strobe_o(wr16), .rd_strobe_o(rd16), .reg_num_o(regn16), .bytesel_o(bs16),
        .wr_data_o(wr_data16), .rd_data_i(rdata)
    );

    typedef struct { int d; logic rd; logic [3:0] regn; logic bs; logic [15:0] data; int unsigned at; } strb_t;
    typedef struct { int d; logic oe; logic [15:0] data; int unsigned at; } ack_t;
    typedef struct { int d; int unsigned at; } rel_t;

    strb_t sq[$];
    ack_t  aq[$];
    rel_t  rq[$];

    int compared   = 0;
    int mismatched = 0;
    int unsigned cyc = 0;
    logic prev_dt8  = 1'b1;
    logic prev_dt16 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic observe(input int d, input logic wr, input logic rd, input logic [3:0] rn,
                           input logic bs, input logic [15:0] wd, input logic dt, input logic pdt,
                           input logic oe, input logic [15:0] bd);
        strb_t s;
        ack_t  a;
        rel_t  r;
        if (wr || rd) begin
            if (sq.size() == 0) begin
                chk($sformatf("unexpected_strobe_dut%0d", d), {30'd0, wr, rd}, 32'd0);
            end else begin
                s = sq.pop_front();
                chk("strobe_dut", d, s.d);
                chk("strobe_cycle", cyc, s.at);
                chk("strobe_rd", rd, s.rd);
                chk("strobe_wr", wr, !s.rd);
                chk("strobe_reg_num", rn, s.regn);
                chk("strobe_bytesel", bs, s.bs);
                if (!s.rd) chk("strobe_wr_data", wd, s.data);
            end
        end
        if (pdt && !dt) begin
            if (aq.size() == 0) begin
                chk($sformatf("unexpected_dtack_dut%0d", d), dt, 1'b1);
            end else begin
                a = aq.pop_front();
                chk("ack_dut", d, a.d);
                chk("ack_cycle", cyc, a.at);
                chk("ack_out_ena", oe, a.oe);
                if (a.oe) chk("ack_bus_data", bd, a.data);
            end
        end
        if (!pdt && dt) begin
            if (rq.size() == 0) begin
                chk($sformatf("unexpected_release_dut%0d", d), dt, 1'b0);
            end else begin
                r = rq.pop_front();
                chk("release_dut", d, r.d);
                chk("release_cycle", cyc, r.at);
                chk("release_out_ena", oe, 1'b0);
            end
        end
    endtask

    // Monitor: samples both ports at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            observe(0, wr8, rd8, regn8, bs8, {8'h00, wr_data8}, dtack8_n, prev_dt8, oe8, {8'h00, bus_data8});
            observe(1, wr16, rd16, regn16, bs16, wr_data16, dtack16_n, prev_dt16, oe16, bus_data16);
        end
        prev_dt8  = dtack8_n;
        prev_dt16 = dtack16_n;
    end

    task automatic set_cs(input int d, input logic v);
        if (d == 0) cs8_n = v;
        else        cs16_n = v;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One complete access: select falls at cycle k, held for 'hold' cycles.
    task automatic access(input int d, input logic rd, input logic [3:0] rn, input logic bs,
                          input logic [15:0] wd, input logic [15:0] rv, input int unsigned hold);
        int unsigned s, c, l, k, m;
        logic [15:0] mask;
        strb_t se;
        ack_t  ae;
        rel_t  re;
        s    = (d == 0) ? 2 : 3;
        c    = (d == 0) ? 1 : 0;
        l    = (d == 0) ? 2 : 1;
        mask = (d == 0) ? 16'h00FF : 16'hFFFF;
        rd_nwr = rd; bytesel = bs; reg_num = rn; wdata = wd; rdata = rv;
        tick(1);
        k  = cyc;
        se = '{d, rd, rn, (d == 1) ? 1'b0 : bs, wd & mask, k + s + c + 1};
        ae = '{d, rd, rv & mask, rd ? (k + s + c + 2 + l) : (k + s + c + 2)};
        sq.push_back(se);
        aq.push_back(ae);
        set_cs(d, 1'b0);
        tick(hold);
        m  = cyc;
        re = '{d, m + s};
        rq.push_back(re);
        set_cs(d, 1'b1);
        tick(s + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        strb_t se;
        ack_t  ae;

        #1 reset_n = 1'b0;
        tick(3);
        chk("rst_dtack8", dtack8_n, 1'b1);
        chk("rst_oe8", oe8, 1'b0);
        chk("rst_strobes8", {wr8, rd8}, 2'b00);
        chk("rst_regs8", {regn8, bs8, wr_data8, bus_data8}, '0);
        chk("rst_dtack16", dtack16_n, 1'b1);
        chk("rst_oe16", oe16, 1'b0);
        chk("rst_regs16", {regn16, bs16, wr16, rd16, wr_data16, bus_data16}, '0);
        reset_n = 1'b1;
        tick(5);

        // 8-bit write and read
        access(0, 1'b0, 4'h3, 1'b1, 16'h00A5, 16'h0000, 10);
        access(0, 1'b1, 4'h7, 1'b0, 16'h0000, 16'h005A, 12);

        // select glitch of a single synchronized cycle: no strobe, no ack
        cs8_n = 1'b0;
        tick(1);
        cs8_n = 1'b1;
        tick(8);
        chk("glitch_dtack8", dtack8_n, 1'b1);
        chk("glitch_oe8", oe8, 1'b0);

        // select held low for 100 cycles: one strobe, DTACK until release
        access(0, 1'b0, 4'h9, 1'b0, 16'h003C, 16'h0000, 100);

        // reset during RDWAIT, select still low after release
        rd_nwr = 1'b1; bytesel = 1'b0; reg_num = 4'h5; rdata = 16'h0077;
        tick(1);
        k  = cyc;
        se = '{0, 1'b1, 4'h5, 1'b0, 16'h0000, k + 4};
        sq.push_back(se);
        cs8_n = 1'b0;
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("rdwait_rst_dtack8", dtack8_n, 1'b1);
        chk("rdwait_rst_oe8", oe8, 1'b0);
        chk("rdwait_rst_reg_num8", regn8, 4'h0);
        tick(3);
        reset_n = 1'b1;
        tick(10);
        chk("held_low_no_ack_dtack8", dtack8_n, 1'b1);
        cs8_n = 1'b1;
        tick(4);
        access(0, 1'b1, 4'h2, 1'b0, 16'h0000, 16'h00C3, 12);

        // reset during ACK of a write drops DTACK immediately
        rd_nwr = 1'b0; reg_num = 4'h1; wdata = 16'h0011;
        tick(1);
        k  = cyc;
        se = '{0, 1'b0, 4'h1, 1'b0, 16'h0011, k + 4};
        ae = '{0, 1'b0, 16'h0000, k + 5};
        sq.push_back(se);
        aq.push_back(ae);
        cs8_n = 1'b0;
        tick(7);
        reset_n = 1'b0;
        #1;
        chk("ack_rst_dtack8", dtack8_n, 1'b1);
        chk("ack_rst_oe8", oe8, 1'b0);
        cs8_n = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(6);

        // 16-bit: bytesel forced low, back-to-back accesses
        access(1, 1'b0, 4'hA, 1'b1, 16'hBEEF, 16'h0000, 10);
        access(1, 1'b1, 4'h4, 1'b1, 16'h0000, 16'h1234, 10);
        access(1, 1'b0, 4'hF, 1'b0, 16'hCAFE, 16'h0000, 8);

        tick(6);
        chk("pending_strobes", sq.size(), 0);
        chk("pending_acks", aq.size(), 0);
        chk("pending_releases", rq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
